// File: rtl/bcd_to_bin.sv
// bcd_to_bin
// Sequential BCD-to-binary converter. A three-digit BCD triple (hundreds,
// tens, units) is accepted through a valid/ready handshake. It is then folded
// into a 10-bit accumulator one digit per clock (acc*10 + digit). The binary
// result goes out through a second valid/ready handshake. It carries an
// out-of-range flag and a flag for illegal BCD digits.
//
// Parameters
//   OUT_W     width of bin_out (7..10)
//   SATURATE  1: out-of-range results clamp to 2^OUT_W-1
//             0: out-of-range results wrap to the low OUT_W bits
//
// Ports
//   clk           rising-edge master clock
//   btn_reset     active-low reset, asserts asynchronously, releases on a clock edge
//   in_valid      digit triple presented
//   in_ready      converter idle and able to take a triple
//   bcd_centenas  hundreds digit
//   bcd_decenas   tens digit
//   bcd_unidades  units digit
//   out_valid     result available
//   out_ready     consumer takes the result
//   bin_out       binary result
//   out_of_range  result exceeded 2^OUT_W-1
//   digit_err     some input nibble was above 9
module bcd_to_bin #(
  parameter int OUT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             btn_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       bcd_centenas,
  input  logic [3:0]       bcd_decenas,
  input  logic [3:0]       bcd_unidades,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] bin_out,
  output logic             out_of_range,
  output logic             digit_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [9:0]       MAX_VAL = 10'((1 << OUT_W) - 1);
  localparam logic [OUT_W-1:0] SAT_VAL = {OUT_W{1'b1}};

  logic [1:0] rst_sync;
  logic       rst_n;
  logic [1:0] state;
  logic [1:0] step;
  logic [9:0] acc;
  logic [9:0] acc_next;
  logic [3:0] dig_h;
  logic [3:0] dig_t;
  logic [3:0] dig_u;
  logic [3:0] cur_digit;
  logic       err_pend;
  logic       too_big;

  // The reset asserts at once, but it is released only on a clock edge, so
  // every flop leaves reset in the same cycle.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Handshake outputs are decoded from registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The digit feeding this step is taken from the copies latched at accept,
  // so the converter ignores later changes on the input pins.
  always_comb begin
    cur_digit = dig_u;
    case (step)
      2'd0:    cur_digit = dig_h;
      2'd1:    cur_digit = dig_t;
      default: cur_digit = dig_u;
    endcase
  end

  // acc*10 is built as acc*8 + acc*2. Legal digits keep the sum at or
  // below 999, so 10 bits never overflow.
  assign acc_next = (acc << 3) + (acc << 1) + {6'b0, cur_digit};
  assign too_big  = (acc_next > MAX_VAL);

  // A bad digit is noted at accept but reported one edge later. This gives
  // the error result the same registered path as a normal result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= 2'd0;
      acc          <= 10'd0;
      dig_h        <= 4'd0;
      dig_t        <= 4'd0;
      dig_u        <= 4'd0;
      err_pend     <= 1'b0;
      bin_out      <= '0;
      out_of_range <= 1'b0;
      digit_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dig_h    <= bcd_centenas;
            dig_t    <= bcd_decenas;
            dig_u    <= bcd_unidades;
            acc      <= 10'd0;
            step     <= 2'd0;
            err_pend <= (bcd_centenas > 4'd9) || (bcd_decenas > 4'd9) ||
                        (bcd_unidades > 4'd9);
            state    <= CONV;
          end
        end
        CONV: begin
          if (err_pend) begin
            bin_out      <= '0;
            out_of_range <= 1'b0;
            digit_err    <= 1'b1;
            state        <= DONE;
          end else begin
            acc <= acc_next;
            if (step == 2'd2) begin
              digit_err    <= 1'b0;
              out_of_range <= too_big;
              if (too_big && SATURATE) bin_out <= SAT_VAL;
              else                     bin_out <= acc_next[OUT_W-1:0];
              state        <= DONE;
            end else begin
              step <= step + 2'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter; the inverse of the binary-to-BCD path that feeds the 7-segment display chain.
- Accepts three BCD digits (hundreds, tens, units) through a valid/ready handshake.
- Converts them by multiply-by-10-and-accumulate, one digit per clock.
- Returns the binary value through a second valid/ready handshake, with range and digit-error flags.
- Intended consumers: decimal-entry front ends, such as keypad or switch digit entry, that drive the 8-bit counter/display path.

Parameters:
- OUT_W, 8: width of bin_out. Legal range 7..10. The maximum representable value is 2^OUT_W-1.
- SATURATE, 1: on out-of-range results, 1 drives bin_out to 2^OUT_W-1; 0 drives the low OUT_W bits of the sum.

Ports:
- clk  in  1  master clock; all flops on rising edge
- btn_reset  in  1  reset, asynchronous assert, active-low; synchronous deassert
- in_valid  in  1  digit triple presented
- in_ready  out  1  block can accept a triple
- bcd_centenas  in  4  hundreds digit
- bcd_decenas  in  4  tens digit
- bcd_unidades  in  4  units digit
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- bin_out  out  OUT_W  binary result
- out_of_range  out  1  value exceeds 2^OUT_W-1
- digit_err  out  1  at least one input nibble was greater than 9

Behaviour:
- Reset (btn_reset=0, any time, including mid-conversion): state=IDLE; in_ready=1; out_valid=0; bin_out=0; out_of_range=0; digit_err=0; accumulator=0; step=0. Any in-flight conversion is discarded.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch the three digits, clear the accumulator, set step=0.
  - If any digit is greater than 9: go to DONE with digit_err=1, bin_out=0, out_of_range=0. out_valid rises on the next edge.
  - Otherwise go to CONV.
- CONV:
  - in_ready=0.
  - Each edge: acc <= acc*10 + digit[step], using the digit order hundreds, tens, units. acc is 10 bits wide (maximum 999, no internal overflow).
  - After step 2, go to DONE. Load bin_out and out_of_range from the final acc; set out_valid=1 and digit_err=0.
- Latency: out_valid is high exactly 3 clocks after the accepting edge for a valid triple, and 1 clock after it for a digit_err triple.
- Range rule:
  - out_of_range=1 when the final acc is greater than 2^OUT_W-1 (for OUT_W=8, that is acc greater than 255).
  - bin_out in that case is 2^OUT_W-1 when SATURATE=1, otherwise acc[OUT_W-1:0].
  - acc equal to exactly 2^OUT_W-1 is in range.
- DONE:
  - in_ready=0. out_valid=1.
  - bin_out and both flags are held stable until handshake.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. in_ready is 1 on the following cycle.
  - The result is never dropped or overwritten while out_valid=1.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored when out_valid=0.
  - out_ready may already be high when out_valid rises; the handshake then completes on the next edge.
  - No combinational path from any input to any output. in_ready and out_valid are decoded from registered state only.
  - Input digits are sampled only on the accepting edge; changes after that edge have no effect.
- Throughput: one conversion per 5 clocks with continuous valid/ready (accept, 3 CONV, DONE handshake).
- bin_out and the flags keep their last values after the handshake until the next result loads.

Test Plan:
- Reset mid-CONV: drive btn_reset=0 with step=1 -> immediately in_ready=1, out_valid=0, bin_out=0. The next triple (0,4,2) returns 42.
- Triple (2,5,5), OUT_W=8, out_ready=1 -> out_valid exactly 3 clocks after accept; bin_out=255, out_of_range=0, digit_err=0. in_ready returns the cycle after the handshake.
- Triple (2,5,6) with SATURATE=1 -> bin_out=255, out_of_range=1. Same triple with SATURATE=0 -> bin_out=0, out_of_range=1. Triple (9,9,9) with SATURATE=0 -> bin_out=231 (999 mod 256), out_of_range=1.
- Triple (1,0xA,3) -> out_valid 1 clock after accept; digit_err=1, bin_out=0.
- Back-pressure: out_ready=0 for 10 clocks after a result of 128 from triple (1,2,8) -> out_valid stays 1, bin_out stays 128, in_ready stays 0. A new in_valid pulse with (0,0,7) is ignored. Raising out_ready completes the handshake, then (0,0,7) is accepted and returns 7.
- Back-to-back: continuous in_valid and out_ready with triples (0,0,0), (0,1,0), (1,0,0) -> outputs 0, 10, 100 in order, one result every 5 clocks. Changing the digits during CONV does not alter the result.
